plic_claim_master: RTL and testbench

- Hart-side initiator for one PLIC target context.
- Watches that context's interrupt line and claims the pending source by reading the claim register as an APB master.
- Hands the claimed ID to a local handler over a valid/ready handshake, then writes the ID back to the complete register once the handler reports done.
- Also programs the context's priority threshold on request.
- Sits between the PLIC APB slave port and core-side interrupt logic.

---
 rtl/plic_claim_master.sv | 161 ++++++++++++++++
 tb/tb_plic_claim_master.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plic_claim_master.sv
// PLIC claim/complete initiator for one target context.
// Claims via APB read, hands the ID off, completes via APB write.
module plic_claim_master #(
    parameter int SRC_N  = 8,
    parameter int CTX    = 0,
    parameter int PRIO_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              psel,
    output logic              penable,
    input  logic              pready,
    output logic [25:0]       paddr,
    output logic              pwrite,
    output logic [31:0]       pwdata,
    output logic [3:0]        pwstrb,
    input  logic [31:0]       prdata,
    input  logic              pslverr,
    input  logic              int_tgt,
    input  logic              thr_valid,
    input  logic [PRIO_W-1:0] thr_data,
    output logic              thr_ready,
    output logic              irq_valid,
    output logic [4:0]        irq_id,
    input  logic              irq_ready,
    input  logic              svc_done,
    output logic              busy,
    output logic              err
);

    localparam logic [25:0] THR_ADDR = 26'(32'h0020_0000 + 32'(CTX) * 32'h1000);
    localparam logic [25:0] CLM_ADDR = THR_ADDR + 26'd4;

    typedef enum logic [3:0] {
        IDLE,
        THR_SETUP,
        THR_ACCESS,
        CLM_SETUP,
        CLM_ACCESS,
        DELIVER,
        SERVICE,
        CMP_SETUP,
        CMP_ACCESS
    } state_e;

    state_e state_q;

    logic id_zero;
    logic id_ok;

    assign id_zero = (prdata == 32'd0);
    assign id_ok   = !id_zero && (prdata <= 32'(SRC_N));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            pwstrb    <= '0;
            thr_ready <= 1'b0;
            irq_valid <= 1'b0;
            irq_id    <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            thr_ready <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // threshold programming takes priority over claiming
                    if (thr_valid) begin
                        state_q <= THR_SETUP;
                        psel    <= 1'b1;
                        paddr   <= THR_ADDR;
                        pwrite  <= 1'b1;
                        pwdata  <= 32'(thr_data);
                        pwstrb  <= 4'hF;
                        busy    <= 1'b1;
                    end else if (int_tgt) begin
                        state_q <= CLM_SETUP;
                        psel    <= 1'b1;
                        paddr   <= CLM_ADDR;
                        pwrite  <= 1'b0;
                        pwdata  <= '0;
                        pwstrb  <= '0;
                        busy    <= 1'b1;
                    end
                end
                THR_SETUP: begin
                    penable <= 1'b1;
                    state_q <= THR_ACCESS;
                end
                THR_ACCESS: begin
                    if (pready) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        thr_ready <= 1'b1;
                        err       <= err | pslverr;
                        busy      <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                CLM_SETUP: begin
                    penable <= 1'b1;
                    state_q <= CLM_ACCESS;
                end
                CLM_ACCESS: begin
                    if (pready) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        if (!pslverr && id_ok) begin
                            irq_id    <= prdata[4:0];
                            irq_valid <= 1'b1;
                            state_q   <= DELIVER;
                        end else begin
                            // a zero ID is a spurious claim, not a fault
                            err     <= err | pslverr | !id_zero;
                            busy    <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                DELIVER: begin
                    if (irq_ready) begin
                        irq_valid <= 1'b0;
                        state_q   <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (svc_done) begin
                        state_q <= CMP_SETUP;
                        psel    <= 1'b1;
                        paddr   <= CLM_ADDR;
                        pwrite  <= 1'b1;
                        pwdata  <= {27'd0, irq_id};
                        pwstrb  <= 4'hF;
                    end
                end
                CMP_SETUP: begin
                    penable <= 1'b1;
                    state_q <= CMP_ACCESS;
                end
                CMP_ACCESS: begin
                    if (pready) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        err     <= err | pslverr;
                        busy    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_plic_claim_master.sv
// Bench for plic_claim_master: APB slave model, transfer scoreboard
// and per-cycle check of the handshake outputs.
module tb_plic_claim_master;

    localparam logic [25:0] THR = 26'h202000;
    localparam logic [25:0] CLM = 26'h202004;

    logic        clk, rst;
    logic        psel, penable, pready, pwrite, pslverr;
    logic [25:0] paddr;
    logic [31:0] pwdata, prdata;
    logic [3:0]  pwstrb;
    logic        int_tgt, thr_valid, thr_ready;
    logic [3:0]  thr_data;
    logic        irq_valid, irq_ready, svc_done, busy, err;
    logic [4:0]  irq_id;

    plic_claim_master #(.SRC_N(8), .CTX(2), .PRIO_W(4)) dut (
        .clk(clk), .rst(rst),
        .psel(psel), .penable(penable), .pready(pready),
        .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
        .pwstrb(pwstrb), .prdata(prdata), .pslverr(pslverr),
        .int_tgt(int_tgt), .thr_valid(thr_valid), .thr_data(thr_data),
        .thr_ready(thr_ready), .irq_valid(irq_valid), .irq_id(irq_id),
        .irq_ready(irq_ready), .svc_done(svc_done),
        .busy(busy), .err(err)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [25:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic [31:0] rdata;
        logic        slverr;
    } xfer_t;

    xfer_t exp_q[$];
    xfer_t cur;
    int    n_chk = 0;
    int    n_err = 0;
    int    wait_cnt, acc_cnt, thr_pulses;
    bit    pend, hs_pend, thr_exp, prev_psel;
    logic  exp_err, exp_vld;
    logic  [4:0] exp_id;
    logic  [25:0] s_addr;
    logic  [31:0] s_wdata;
    logic  [3:0]  s_strb;
    logic         s_wr;

    function automatic void chk(input bit ok, input string nm,
                                input logic [31:0] act,
                                input logic [31:0] exp);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endfunction

    function automatic void push(input logic [25:0] a, input logic w,
                                 input logic [31:0] wd, input logic [3:0] st,
                                 input int ws, input logic [31:0] rd,
                                 input logic se);
        xfer_t t;
        t.addr = a; t.wr = w; t.wdata = wd; t.strb = st;
        t.waits = ws; t.rdata = rd; t.slverr = se;
        exp_q.push_back(t);
    endfunction

    // slave model plus transaction-level expectations
    always @(negedge clk) begin
        if (rst) begin
            pready = 0; pslverr = 0; prdata = 0;
            pend = 0; hs_pend = 0; prev_psel = 0;
            exp_err = 0; exp_vld = 0; exp_id = 0;
            exp_q.delete();
        end else begin
            thr_exp = 0;
            if (hs_pend) begin
                exp_vld = 0;
                hs_pend = 0;
            end
            if (pend) begin
                pend = 0;
                chk(acc_cnt == cur.waits + 1, "access_cycles", acc_cnt, cur.waits + 1);
                chk(!psel && !penable, "bus_drop", {psel, penable}, 0);
                if (cur.slverr) exp_err = 1;
                else if (!cur.wr) begin
                    if (cur.rdata >= 1 && cur.rdata <= 8) begin
                        exp_vld = 1;
                        exp_id = cur.rdata[4:0];
                    end else if (cur.rdata != 0) exp_err = 1;
                end
                thr_exp = cur.wr && cur.addr == THR;
                pready = 0; pslverr = 0; prdata = 0;
            end
            chk(thr_ready == thr_exp, "thr_ready", thr_ready, thr_exp);
            if (thr_ready) thr_pulses++;
            chk(err == exp_err, "err", err, exp_err);
            chk(irq_valid == exp_vld, "irq_valid", irq_valid, exp_vld);
            if (exp_vld) chk(irq_id == exp_id, "irq_id", irq_id, exp_id);
            if (psel) chk(busy, "busy_in_xfer", busy, 1);
            chk(!(penable && !psel), "penable_wo_psel", penable, 0);
            if (psel && !penable) begin
                chk(!prev_psel, "back_to_back", prev_psel, 0);
                if (exp_q.size() == 0) begin
                    chk(0, "unexpected_xfer", paddr, 0);
                    cur.addr = paddr; cur.wr = pwrite; cur.wdata = pwdata;
                    cur.strb = pwstrb; cur.waits = 0; cur.rdata = 0;
                    cur.slverr = 0;
                end else begin
                    cur = exp_q.pop_front();
                    chk(paddr == cur.addr, "paddr", paddr, cur.addr);
                    chk(pwrite == cur.wr, "pwrite", pwrite, cur.wr);
                    chk(pwdata == cur.wdata, "pwdata", pwdata, cur.wdata);
                    chk(pwstrb == cur.strb, "pwstrb", pwstrb, cur.strb);
                end
                s_addr = paddr; s_wr = pwrite; s_wdata = pwdata; s_strb = pwstrb;
                acc_cnt = 0;
                wait_cnt = cur.waits;
            end else if (psel && penable) begin
                acc_cnt++;
                chk(paddr == s_addr && pwrite == s_wr && pwdata == s_wdata
                    && pwstrb == s_strb, "access_stable", paddr, s_addr);
                if (wait_cnt == 0) begin
                    pready = 1;
                    prdata = cur.wr ? 32'd0 : cur.rdata;
                    pslverr = cur.slverr;
                    pend = 1;
                end else begin
                    wait_cnt--;
                end
            end
            if (irq_valid && irq_ready) hs_pend = 1;
            prev_psel = psel;
        end
    end

    task automatic wait_until(input int what, input int budget, input string nm);
        bit hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(posedge clk); #1;
            case (what)
                0: hit = psel;
                1: hit = irq_valid;
                2: hit = !busy;
                default: hit = penable;
            endcase
        end
        chk(hit, nm, hit, 1);
    endtask

    task automatic serve();
        wait_until(1, 40, "wait_irq");
        irq_ready = 1;
        @(posedge clk); #1;
        irq_ready = 0;
        svc_done = 1;
        @(posedge clk); #1;
        svc_done = 0;
        wait_until(2, 40, "wait_idle");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=%h want=%h", 0, 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst = 1; int_tgt = 0; thr_valid = 0; thr_data = 0;
        irq_ready = 0; svc_done = 0; thr_pulses = 0;
        repeat (3) @(posedge clk);
        #1;
        chk({psel, penable, pwrite, busy, err, irq_valid, thr_ready} == 0,
            "reset_ctl", {psel, penable, pwrite, busy, err, irq_valid, thr_ready}, 0);
        chk(paddr == 0 && pwdata == 0 && pwstrb == 0 && irq_id == 0,
            "reset_data", paddr, 0);
        rst = 0;

        // basic claim with minimum latency, svc_done during handshake ignored
        push(CLM, 0, 0, 0, 0, 5, 0);
        push(CLM, 1, 5, 4'hF, 0, 0, 0);
        @(posedge clk); #1;
        int_tgt = 1;
        @(posedge clk); #1;
        chk(psel && !penable, "lat_setup", {psel, penable}, 2'b10);
        chk(paddr == 26'h202004, "lat_addr", paddr, 26'h202004);
        int_tgt = 0;
        @(posedge clk); #1;
        chk(psel && penable, "lat_access", {psel, penable}, 2'b11);
        @(posedge clk); #1;
        chk(irq_valid && irq_id == 5, "lat_irq", {irq_valid, irq_id}, {1'b1, 5'd5});
        irq_ready = 1; svc_done = 1;
        @(posedge clk); #1;
        irq_ready = 0; svc_done = 0;
        repeat (4) @(posedge clk);
        #1;
        chk(!psel && busy, "svc_early_ignored", {psel, busy}, 2'b01);
        svc_done = 1;
        @(posedge clk); #1;
        svc_done = 0;
        wait_until(2, 20, "t1_idle");
        chk(exp_q.size() == 0, "t1_done", exp_q.size(), 0);

        // threshold wins over a simultaneous interrupt
        t0 = thr_pulses;
        push(THR, 1, 3, 4'hF, 0, 0, 0);
        push(CLM, 0, 0, 0, 0, 2, 0);
        push(CLM, 1, 2, 4'hF, 0, 0, 0);
        thr_valid = 1; thr_data = 3; int_tgt = 1;
        @(posedge clk); #1;
        thr_valid = 0;
        wait_until(1, 30, "t2_irq");
        int_tgt = 0;
        serve();
        chk(thr_pulses - t0 == 1, "thr_pulse_cnt", thr_pulses - t0, 1);
        chk(exp_q.size() == 0, "t2_done", exp_q.size(), 0);

        // spurious claim
        push(CLM, 0, 0, 0, 0, 0, 0);
        int_tgt = 1;
        wait_until(0, 10, "t3_psel");
        int_tgt = 0;
        wait_until(2, 20, "t3_idle");
        chk(!err && !busy && !irq_valid, "spurious", {err, busy, irq_valid}, 0);

        // wait states on both claim and complete
        push(CLM, 0, 0, 0, 3, 7, 0);
        push(CLM, 1, 7, 4'hF, 3, 0, 0);
        int_tgt = 1;
        wait_until(0, 10, "t6_psel");
        int_tgt = 0;
        serve();
        chk(exp_q.size() == 0, "t6_done", exp_q.size(), 0);

        // slave error on claim, level still high reclaims
        push(CLM, 0, 0, 0, 0, 3, 1);
        push(CLM, 0, 0, 0, 0, 4, 0);
        push(CLM, 1, 4, 4'hF, 0, 0, 0);
        int_tgt = 1;
        wait_until(1, 40, "t5_irq");
        int_tgt = 0;
        serve();
        chk(err, "slverr_sticky", err, 1);

        // reset during claim access
        push(CLM, 0, 0, 0, 6, 1, 0);
        int_tgt = 1;
        wait_until(3, 10, "t7_pen");
        @(posedge clk); #1;
        rst = 1;
        #1;
        chk({psel, penable, pwrite, busy, err, irq_valid, thr_ready} == 0,
            "rst_mid_ctl", {psel, penable, pwrite, busy, err, irq_valid, thr_ready}, 0);
        chk(paddr == 0 && pwdata == 0 && pwstrb == 0 && irq_id == 0,
            "rst_mid_data", irq_id, 0);
        @(negedge clk); #1;
        push(CLM, 0, 0, 0, 0, 6, 0);
        push(CLM, 1, 6, 4'hF, 0, 0, 0);
        @(posedge clk); #1;
        rst = 0;
        wait_until(1, 20, "t7_irq");
        chk(irq_id == 6, "t7_id", irq_id, 6);
        int_tgt = 0;
        serve();

        // out-of-range claim ID
        push(CLM, 0, 0, 0, 0, 9, 0);
        int_tgt = 1;
        wait_until(0, 10, "t4_psel");
        int_tgt = 0;
        wait_until(2, 20, "t4_idle");
        chk(err && !irq_valid, "bad_id", {err, irq_valid}, 2'b10);

        repeat (5) @(posedge clk);
        chk(exp_q.size() == 0, "all_consumed", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
